// File: rtl/stream_wb_control.sv
// Control FSM for a 4-way stream/write-back buffer: zero-wait hits; miss responds 1 cycle after pmem_resp.
// Upstream mem_read is held until mem_resp; pmem_read stays high until pmem_resp. Optional flush port: STREAM_WB_FLUSH_EN.
module stream_wb_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef STREAM_WB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             mem_read,
    output logic             mem_resp,
    output logic             pmem_read,
    input  logic             pmem_resp,
    input  logic             hit,
    input  logic [1:0]       cline_and,
    input  logic [2:0]       lru_out,
    input  logic             valid0_out,
    input  logic             valid1_out,
    input  logic             valid2_out,
    input  logic             valid3_out,
    output logic             valid0_write,
    output logic             valid1_write,
    output logic             valid2_write,
    output logic             valid3_write,
    output logic             valid_in,
    output logic             tag0_write,
    output logic             tag1_write,
    output logic             tag2_write,
    output logic             tag3_write,
    output logic             data0_write,
    output logic             data1_write,
    output logic             data2_write,
    output logic             data3_write,
    output logic             lru_write,
    output logic [2:0]       lru_in,
    output logic             load_pmem,
    output logic             tag_mux_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_FILL, S_RESPOND} state_t;

    state_t           state_q, state_d;
    logic [1:0]       victim_q, victim_d;
    logic [CNT_W-1:0] hit_count_q, miss_count_q;
    logic             hit_inc, miss_inc;
    logic [3:0]       valid_we, tag_we, data_we, valid_vec;

    assign valid_vec = {valid3_out, valid2_out, valid1_out, valid0_out};

    function automatic logic [2:0] plru_update(input logic [1:0] way, input logic [2:0] lru);
        logic [2:0] n;
        n    = lru;
        n[0] = ~way[1];
        if (way[1]) n[2] = ~way[0];
        else        n[1] = ~way[0];
        return n;
    endfunction

    // Empty ways are filled lowest-first; PLRU only decides once the buffer is full.
    function automatic logic [1:0] pick_victim(input logic [3:0] vld, input logic [2:0] lru);
        logic [1:0] v;
        if      (!vld[0]) v = 2'd0;
        else if (!vld[1]) v = 2'd1;
        else if (!vld[2]) v = 2'd2;
        else if (!vld[3]) v = 2'd3;
        else              v = {lru[0], lru[0] ? lru[2] : lru[1]};
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        valid_we    = 4'b0000;
        tag_we      = 4'b0000;
        data_we     = 4'b0000;
        valid_in    = 1'b0;
        lru_write   = 1'b0;
        lru_in      = lru_out;
        load_pmem   = 1'b0;
        tag_mux_sel = 1'b0;
        case (state_q)
            S_INIT: begin
                valid_we  = 4'b1111;
                lru_write = 1'b1;
                lru_in    = 3'b000;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
`ifdef STREAM_WB_FLUSH_EN
                if (flush) begin
                    valid_we  = 4'b1111;
                    lru_write = 1'b1;
                    lru_in    = 3'b000;
                end else
`endif
                if (mem_read) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        lru_write = 1'b1;
                        lru_in    = plru_update(cline_and, lru_out);
                        hit_inc   = 1'b1;
                    end else begin
                        load_pmem = 1'b1;
                        miss_inc  = 1'b1;
                        victim_d  = pick_victim(valid_vec, lru_out);
                        state_d   = S_FILL;
                    end
                end
            end
            S_FILL: begin
                tag_mux_sel = 1'b1;
                pmem_read   = 1'b1;
                // A reset landing on the response cycle must not leave a half-written line.
                if (pmem_resp && !reset) begin
                    valid_we  = 4'b0001 << victim_q;
                    tag_we    = 4'b0001 << victim_q;
                    data_we   = 4'b0001 << victim_q;
                    valid_in  = 1'b1;
                    lru_write = 1'b1;
                    lru_in    = plru_update(victim_q, lru_out);
                    state_d   = S_RESPOND;
                end
            end
            S_RESPOND: begin
                tag_mux_sel = 1'b1;
                mem_resp    = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            victim_q     <= 2'd0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (hit_inc && (hit_count_q != {CNT_W{1'b1}}))
                hit_count_q <= hit_count_q + CNT_W'(1);
            if (miss_inc && (miss_count_q != {CNT_W{1'b1}}))
                miss_count_q <= miss_count_q + CNT_W'(1);
        end
    end

    assign {valid3_write, valid2_write, valid1_write, valid0_write} = valid_we;
    assign {tag3_write, tag2_write, tag1_write, tag0_write}         = tag_we;
    assign {data3_write, data2_write, data1_write, data0_write}     = data_we;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule
